conv1d_stream_pp: RTL and testbench
===================================

Name: conv1d_stream_pp

Overview:
- Streaming 1-D convolution layer. Computes y[k] = sum over j of x[k+j]*f[j], for k = 0..LENX-LENF.
- Filter words are loaded over a stream port. Input vectors arrive over a valid/ready stream into a ping-pong (double) buffer, so the next vector loads while the current one is computed.
- P MAC lanes compute P outputs concurrently.
- Arithmetic saturates. Optional ReLU. Sits between stream sources and the next layer in the generated network.

Parameters:
- WIDTH, 16, signed data/coefficient width.
- LENX, 8, input vector length.
- LENF, 4, filter length (LENF <= LENX).
- P, 1, parallel MAC lanes; must divide LENX-LENF+1.
- Derived localparams: NOUT = LENX-LENF+1; ADDRX = $clog2(LENX); ADDRF = $clog2(LENF).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- s_data_in_f  in  WIDTH  filter coefficient, f[0] first.
- s_valid_f  in  1  filter word valid.
- s_ready_f  out  1  filter word accepted when valid&ready.
- s_data_in_x  in  WIDTH  input sample, x[0] first.
- s_valid_x  in  1  input valid.
- s_ready_x  out  1  input ready.
- relu_en  in  1  ReLU mode; sampled when a vector's compute starts.
- m_data_out_y  out  WIDTH  output sample, y[0] first.
- m_valid_y  out  1  output valid.
- m_ready_y  in  1  output ready.

Behaviour:
- One clock, clk. Reset is synchronous and active-high.
- Reset values: s_ready_f=1, s_ready_x=1, m_valid_y=0, m_data_out_y=0. Both banks empty, filter count 0, compute FSM IDLE.
- Reset mid-operation discards all data, including the filter.

Filter load:
- Register file of LENF words. s_ready_f=1 until LENF words are accepted, then 0 until the next reset.

Input loader:
- Writes bank wr_bank at address wr_cnt on each x handshake.
- When wr_cnt reaches LENX-1 and is handshaken, the bank is marked full and wr_bank toggles.
- s_ready_x = 1 iff the bank addressed by wr_bank is not full. The loader may fill both banks before the filter is loaded.
- A bank is freed on the cycle its compute finishes its last group (the results are in the output register). A freed bank is writable the next cycle.

Compute FSM, states IDLE, MAC, HOLD:
- IDLE -> MAC when rd_bank is full, the filter is loaded and the output register is empty.
  - Capture relu_en. Clear the P accumulators. Set tap j=0 and group base k0=0.
- MAC: one tap per cycle. Lane i accumulates x[k0+i+j]*f[j]. Banks are register arrays, so there are no read-latency bubbles.
- After tap LENF-1, the lane results load into the P-entry output register. State goes to HOLD.
- HOLD: waits until all P entries have been handshaken out.
  - If k0+P < NOUT: k0 += P, clear the accumulators, go to MAC.
  - Otherwise: free rd_bank, toggle rd_bank, go to IDLE.
- Same-cycle start: if the last output handshake and a full next bank coincide, MAC of the next vector begins the following cycle. No extra bubble.

Output:
- Entries are emitted lane 0 first, one per m_valid_y&m_ready_y.
- m_data_out_y is stable while m_valid_y=1 and m_ready_y=0.
- Latency: with the filter loaded and the FSM IDLE, m_valid_y rises LENF+1 cycles after the handshake of x[LENX-1].

Arithmetic (per tap):
- Full 2*WIDTH signed product, saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- Added to the accumulator in WIDTH+1 bits, then saturated to the same range. Tap order is j ascending.
- After the last tap, if the captured relu_en=1, negative results become 0.

Test Plan:
- WIDTH=8, LENX=8, LENF=4, P=1; f={1,2,3,4}; x=1..8, m_ready_y=1 -> y={30,40,50,60,70}. First m_valid_y 5 cycles after x[7] handshake.
- Same config; f all 127, x all 127 -> every y=127 (product and accumulator saturate). f all -128, x all 127, relu_en=0 -> every y=-128.
- f={-1,-1,-1,-1}, x=1..8: relu_en=0 -> y={-10,-14,-18,-22,-26}; relu_en=1 -> all 0. relu_en toggled mid-vector leaves that vector unaffected.
- Two vectors streamed back to back with s_valid_x held high and the filter preloaded -> s_ready_x never drops during the 16 words. Both 5-output sequences are correct and in order.
- Back-pressure: m_ready_y=0 for 10 cycles when the first y asserts -> m_valid_y=1 and m_data_out_y=30 held steady. With a third vector offered, s_ready_x falls after both banks are full.
- P=5 and reset asserted mid-MAC -> all outputs return to reset values, s_ready_f=1. A fresh filter+vector load then yields {30,40,50,60,70}.

Source files
------------

// File: rtl/conv1d_stream_pp_if.sv
// Stream bundle for conv1d_stream_pp: filter-word and sample inputs, result output.
// The slave modport is the layer's view; master is the surrounding source/sink.
interface conv1d_stream_pp_if #(
   parameter int WIDTH = 16
);
   logic [WIDTH-1:0] s_data_in_f;
   logic             s_valid_f;
   logic             s_ready_f;
   logic [WIDTH-1:0] s_data_in_x;
   logic             s_valid_x;
   logic             s_ready_x;
   logic             relu_en;
   logic [WIDTH-1:0] m_data_out_y;
   logic             m_valid_y;
   logic             m_ready_y;

   modport slave (
      input  s_data_in_f, s_valid_f,
      output s_ready_f,
      input  s_data_in_x, s_valid_x,
      output s_ready_x,
      input  relu_en,
      output m_data_out_y, m_valid_y,
      input  m_ready_y
   );

   modport master (
      output s_data_in_f, s_valid_f,
      input  s_ready_f,
      output s_data_in_x, s_valid_x,
      input  s_ready_x,
      output relu_en,
      input  m_data_out_y, m_valid_y,
      output m_ready_y
   );
endinterface

// File: rtl/conv1d_stream_pp.sv
// Streaming saturating 1-D convolution with a ping-pong input buffer and P MAC lanes.
// Lane i of group k0 produces y[k0+i]; one filter tap per cycle.
module conv1d_stream_pp #(
   parameter int WIDTH = 16,
   parameter int LENX  = 8,
   parameter int LENF  = 4,
   parameter int P     = 1
) (
   input logic               clk,
   input logic               reset,
   conv1d_stream_pp_if.slave bus
);
   localparam int NOUT  = LENX - LENF + 1;
   localparam int ADDRX = $clog2(LENX);
   localparam int ADDRF = $clog2(LENF);
   localparam int AXW   = (ADDRX > 0) ? ADDRX : 1;
   localparam int AFW   = (ADDRF > 0) ? ADDRF : 1;
   localparam int FCW   = $clog2(LENF + 1);
   localparam int KW    = $clog2(NOUT + 1);
   localparam int OW    = (P > 1) ? $clog2(P) : 1;

   localparam logic [AXW-1:0] LAST_X = AXW'(LENX - 1);
   localparam logic [AFW-1:0] LAST_F = AFW'(LENF - 1);
   localparam logic [OW-1:0]  LAST_P = OW'(P - 1);
   localparam logic [FCW-1:0] LENF_C = FCW'(LENF);
   localparam logic [KW-1:0]  NOUT_C = KW'(NOUT);
   localparam logic [KW-1:0]  P_C    = KW'(P);

   typedef enum logic [1:0] {IDLE, MAC, HOLD} state_t;
   typedef logic signed [WIDTH-1:0] word_t;

   localparam word_t SMAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam word_t SMIN = {1'b1, {(WIDTH-1){1'b0}}};

   function automatic word_t sat_prod(input logic signed [2*WIDTH-1:0] v);
      if (v[2*WIDTH-1:WIDTH-1] == '0 || v[2*WIDTH-1:WIDTH-1] == '1) return v[WIDTH-1:0];
      return v[2*WIDTH-1] ? SMIN : SMAX;
   endfunction

   function automatic word_t sat_sum(input logic signed [WIDTH:0] v);
      if (v[WIDTH] == v[WIDTH-1]) return v[WIDTH-1:0];
      return v[WIDTH] ? SMIN : SMAX;
   endfunction

   word_t f_q    [LENF];
   word_t bank_q [2][LENX];

   state_t         state_q, state_d;
   logic [FCW-1:0] f_cnt_q, f_cnt_d;
   logic [AXW-1:0] wr_cnt_q, wr_cnt_d;
   logic           wr_bank_q, wr_bank_d;
   logic           rd_bank_q, rd_bank_d;
   logic [1:0]     full_q, full_d;
   logic [AFW-1:0] tap_q, tap_d;
   logic [KW-1:0]  k0_q, k0_d;
   logic           relu_q, relu_d;
   word_t          acc_q [P];
   word_t          acc_d [P];
   word_t          out_q [P];
   word_t          out_d [P];
   logic           out_valid_q, out_valid_d;
   logic [OW-1:0]  out_idx_q, out_idx_d;

   logic f_rdy, x_rdy, f_hs, x_hs, filter_loaded, last_pop, do_start;
   logic [1:0] full_set, full_clr;

   logic [AXW-1:0]            lane_idx  [P];
   logic signed [2*WIDTH-1:0] lane_prod [P];
   word_t                     lane_psat [P];
   logic signed [WIDTH:0]     lane_sum  [P];
   word_t                     acc_nxt   [P];
   word_t                     lane_res  [P];

   assign filter_loaded = (f_cnt_q == LENF_C);
   assign f_rdy         = !filter_loaded;
   assign x_rdy         = !full_q[wr_bank_q];
   assign f_hs          = bus.s_valid_f && f_rdy;
   assign x_hs          = bus.s_valid_x && x_rdy;
   assign last_pop      = out_valid_q && bus.m_ready_y && (out_idx_q == LAST_P);

   // Per-lane tap: saturate the product, then the accumulation, then optional ReLU.
   always_comb begin
      for (int i = 0; i < P; i++) begin
         lane_idx[i]  = AXW'(k0_q) + AXW'(i) + AXW'(tap_q);
         lane_prod[i] = bank_q[rd_bank_q][lane_idx[i]] * f_q[tap_q];
         lane_psat[i] = sat_prod(lane_prod[i]);
         lane_sum[i]  = {acc_q[i][WIDTH-1], acc_q[i]} + {lane_psat[i][WIDTH-1], lane_psat[i]};
         acc_nxt[i]   = sat_sum(lane_sum[i]);
         lane_res[i]  = (relu_q && acc_nxt[i][WIDTH-1]) ? '0 : acc_nxt[i];
      end
   end

   always_comb begin
      // NOTE: every _d starts from its _q so no path through this block can infer a latch.
      state_d     = state_q;
      f_cnt_d     = f_cnt_q;
      wr_cnt_d    = wr_cnt_q;
      wr_bank_d   = wr_bank_q;
      rd_bank_d   = rd_bank_q;
      tap_d       = tap_q;
      k0_d        = k0_q;
      relu_d      = relu_q;
      acc_d       = acc_q;
      out_d       = out_q;
      out_valid_d = out_valid_q;
      out_idx_d   = out_idx_q;
      full_set    = '0;
      full_clr    = '0;
      do_start    = 1'b0;

      if (f_hs) f_cnt_d = f_cnt_q + 1'b1;

      if (x_hs) begin
         if (wr_cnt_q == LAST_X) begin
            wr_cnt_d            = '0;
            full_set[wr_bank_q] = 1'b1;
            wr_bank_d           = !wr_bank_q;
         end else begin
            wr_cnt_d = wr_cnt_q + 1'b1;
         end
      end

      if (out_valid_q && bus.m_ready_y) begin
         if (out_idx_q == LAST_P) begin
            out_valid_d = 1'b0;
            out_idx_d   = '0;
         end else begin
            out_idx_d = out_idx_q + 1'b1;
         end
      end

      case (state_q)
         IDLE: if (full_q[rd_bank_q] && filter_loaded && !out_valid_q) do_start = 1'b1;
         MAC: begin
            acc_d = acc_nxt;
            tap_d = tap_q + 1'b1;
            if (tap_q == LAST_F) begin
               out_d       = lane_res;
               out_valid_d = 1'b1;
               out_idx_d   = '0;
               state_d     = HOLD;
               // The bank is no longer read once its last group sits in the output register.
               if (k0_q + P_C >= NOUT_C) full_clr[rd_bank_q] = 1'b1;
            end
         end
         HOLD: if (last_pop) begin
            if (k0_q + P_C < NOUT_C) begin
               k0_d    = k0_q + P_C;
               tap_d   = '0;
               acc_d   = '{default: '0};
               state_d = MAC;
            end else begin
               rd_bank_d = !rd_bank_q;
               state_d   = IDLE;
               if (full_q[!rd_bank_q] && filter_loaded) do_start = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (do_start) begin
         state_d = MAC;
         tap_d   = '0;
         k0_d    = '0;
         relu_d  = bus.relu_en;
         acc_d   = '{default: '0};
      end

      full_d = (full_q & ~full_clr) | full_set;
   end

   // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         f_cnt_q     <= '0;
         wr_cnt_q    <= '0;
         wr_bank_q   <= 1'b0;
         rd_bank_q   <= 1'b0;
         full_q      <= '0;
         tap_q       <= '0;
         k0_q        <= '0;
         relu_q      <= 1'b0;
         acc_q       <= '{default: '0};
         out_q       <= '{default: '0};
         out_valid_q <= 1'b0;
         out_idx_q   <= '0;
      end else begin
         state_q     <= state_d;
         f_cnt_q     <= f_cnt_d;
         wr_cnt_q    <= wr_cnt_d;
         wr_bank_q   <= wr_bank_d;
         rd_bank_q   <= rd_bank_d;
         full_q      <= full_d;
         tap_q       <= tap_d;
         k0_q        <= k0_d;
         relu_q      <= relu_d;
         acc_q       <= acc_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         out_idx_q   <= out_idx_d;
      end
   end

   // NOTE: coefficient and sample storage is not reset; the filter count and full flags gate its use.
   always_ff @(posedge clk) begin
      if (f_hs) f_q[f_cnt_q[AFW-1:0]] <= bus.s_data_in_f;
      if (x_hs) bank_q[wr_bank_q][wr_cnt_q] <= bus.s_data_in_x;
   end

   always_comb begin
      bus.s_ready_f    = f_rdy;
      bus.s_ready_x    = x_rdy;
      bus.m_valid_y    = out_valid_q;
      bus.m_data_out_y = out_q[out_idx_q];
   end
endmodule

// File: tb/tb_conv1d_stream_pp.sv
// Self-checking bench for conv1d_stream_pp: fixed vector table, corner sequences and
// randomized streams against a plain-arithmetic convolution model; P=1 and P=5 instances.
module tb_conv1d_stream_pp;
   localparam int W  = 8;
   localparam int LX = 8;
   localparam int LF = 4;
   localparam int NO = LX - LF + 1;

   typedef logic [LF-1:0][W-1:0] fvec_t;
   typedef logic [LX-1:0][W-1:0] xvec_t;
   typedef logic [NO-1:0][W-1:0] yvec_t;
   typedef struct packed {
      fvec_t f;
      xvec_t x;
      logic  relu;
      logic  flip;
      yvec_t y;
   } tv_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic         sel = 1'b0;
   logic [W-1:0] f_data = '0;
   logic [W-1:0] x_data = '0;
   logic         f_valid = 1'b0, x_valid = 1'b0, y_ready = 1'b0, relu = 1'b0;
   logic         f_ready, x_ready, y_valid;
   logic [W-1:0] y_data;

   conv1d_stream_pp_if #(.WIDTH(W)) bus1 ();
   conv1d_stream_pp_if #(.WIDTH(W)) bus5 ();

   assign bus1.s_data_in_f = f_data;
   assign bus1.s_valid_f   = f_valid & ~sel;
   assign bus1.s_data_in_x = x_data;
   assign bus1.s_valid_x   = x_valid & ~sel;
   assign bus1.relu_en     = relu;
   assign bus1.m_ready_y   = y_ready;
   assign bus5.s_data_in_f = f_data;
   assign bus5.s_valid_f   = f_valid & sel;
   assign bus5.s_data_in_x = x_data;
   assign bus5.s_valid_x   = x_valid & sel;
   assign bus5.relu_en     = relu;
   assign bus5.m_ready_y   = y_ready;

   assign f_ready = sel ? bus5.s_ready_f    : bus1.s_ready_f;
   assign x_ready = sel ? bus5.s_ready_x    : bus1.s_ready_x;
   assign y_valid = sel ? bus5.m_valid_y    : bus1.m_valid_y;
   assign y_data  = sel ? bus5.m_data_out_y : bus1.m_data_out_y;

   conv1d_stream_pp #(.WIDTH(W), .LENX(LX), .LENF(LF), .P(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
   conv1d_stream_pp #(.WIDTH(W), .LENX(LX), .LENF(LF), .P(5)) dut5 (.clk(clk), .reset(reset), .bus(bus5));

   int n_checks = 0;
   int n_err    = 0;
   int last_x_cyc, first_valid_cyc, x_stalls, hold_bad, seen;
   int got_q[$];
   int exp_q[$];
   tv_t   tv [5];
   fvec_t fv;
   xvec_t xa, xb, xc;
   xvec_t rv [4];

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic fail_timeout(input string name);
      n_checks++;
      n_err++;
      $display("FAIL %s: timed out waiting for the DUT", name);
   endtask

   function automatic int sat(input int v);
      if (v > 127) return 127;
      if (v < -128) return -128;
      return v;
   endfunction

   // y[k] straight from the arithmetic rules: saturate each product, then each running sum.
   function automatic int model_y(input fvec_t f, input xvec_t x, input logic r, input int k);
      int acc = 0;
      for (int j = 0; j < LF; j++)
         acc = sat(acc + sat(int'($signed(x[k+j])) * int'($signed(f[j]))));
      if (r && acc < 0) acc = 0;
      return acc;
   endfunction

   task automatic do_reset();
      reset   = 1'b1;
      f_valid = 1'b0;
      x_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic send_f(input logic [W-1:0] d);
      int t = 0;
      f_data  = d;
      f_valid = 1'b1;
      while (!f_ready && t < 200) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 200) fail_timeout("filter_word");
      else begin
         @(posedge clk); #1;
      end
      f_valid = 1'b0;
   endtask

   task automatic load_filter(input fvec_t f);
      for (int j = 0; j < LF; j++) send_f(f[j]);
   endtask

   task automatic send_x(input logic [W-1:0] d);
      int t = 0;
      x_data  = d;
      x_valid = 1'b1;
      while (!x_ready && t < 200) begin
         x_stalls++;
         @(posedge clk); #1;
         t++;
      end
      if (t >= 200) fail_timeout("input_word");
      else begin
         @(posedge clk); #1;
         last_x_cyc = cyc;
      end
   endtask

   task automatic send_vec(input xvec_t x, input bit gaps);
      for (int i = 0; i < LX; i++) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            x_valid = 1'b0;
            repeat ($urandom_range(1, 3)) begin
               @(posedge clk); #1;
            end
         end
         send_x(x[i]);
      end
      x_valid = 1'b0;
   endtask

   task automatic collect(input int n, input bit rnd);
      int t = 0;
      got_q.delete();
      first_valid_cyc = -1;
      while (got_q.size() < n && t < 3000) begin
         @(negedge clk);
         t++;
         y_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
         if (y_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (y_valid && y_ready) got_q.push_back(int'($signed(y_data)));
      end
      if (got_q.size() < n) fail_timeout("collect_outputs");
      @(posedge clk); #1;
   endtask

   task automatic compare_outputs(input string name);
      for (int k = 0; k < exp_q.size(); k++)
         if (k < got_q.size()) check($sformatf("%s y[%0d]", name, k), got_q[k], exp_q[k]);
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      // Fixed vectors: expected outputs worked out by hand.
      for (int j = 0; j < LF; j++) tv[0].f[j] = W'(j + 1);
      for (int i = 0; i < LX; i++) tv[0].x[i] = W'(i + 1);
      tv[0].relu = 1'b0; tv[0].flip = 1'b0;
      tv[0].y = {8'd70, 8'd60, 8'd50, 8'd40, 8'd30};

      tv[1].f = {LF{8'h7F}}; tv[1].x = {LX{8'h7F}};
      tv[1].relu = 1'b0; tv[1].flip = 1'b0;
      tv[1].y = {NO{8'h7F}};

      tv[2].f = {LF{8'h80}}; tv[2].x = {LX{8'h7F}};
      tv[2].relu = 1'b0; tv[2].flip = 1'b0;
      tv[2].y = {NO{8'h80}};

      tv[3].f = {LF{8'hFF}}; tv[3].x = tv[0].x;
      tv[3].relu = 1'b0; tv[3].flip = 1'b1;
      tv[3].y = {8'hE6, 8'hEA, 8'hEE, 8'hF2, 8'hF6};

      tv[4].f = {LF{8'hFF}}; tv[4].x = tv[0].x;
      tv[4].relu = 1'b1; tv[4].flip = 1'b1;
      tv[4].y = '0;

      sel = 1'b0;
      do_reset();
      check("reset s_ready_f", int'(f_ready), 1);
      check("reset s_ready_x", int'(x_ready), 1);
      check("reset m_valid_y", int'(y_valid), 0);
      check("reset m_data_out_y", int'(y_data), 0);

      for (int e = 0; e < 5; e++) begin
         relu = tv[e].relu;
         do_reset();
         load_filter(tv[e].f);
         if (e == 0) check("s_ready_f after filter", int'(f_ready), 0);
         send_vec(tv[e].x, 1'b0);
         if (tv[e].flip) begin
            @(posedge clk); #1;
            relu = ~relu;
         end
         collect(NO, 1'b0);
         exp_q.delete();
         for (int k = 0; k < NO; k++) exp_q.push_back(int'($signed(tv[e].y[k])));
         compare_outputs($sformatf("vec%0d", e));
         if (e == 0) check("latency x[7] to m_valid_y", first_valid_cyc - last_x_cyc, LF + 1);
      end

      // Two vectors back to back with the filter preloaded: s_ready_x must never drop.
      fv = tv[0].f;
      xa = tv[0].x;
      for (int i = 0; i < LX; i++) xb[i] = W'(LX - i);
      relu = 1'b0;
      do_reset();
      load_filter(fv);
      x_stalls = 0;
      exp_q.delete();
      for (int k = 0; k < NO; k++) exp_q.push_back(model_y(fv, xa, 1'b0, k));
      for (int k = 0; k < NO; k++) exp_q.push_back(model_y(fv, xb, 1'b0, k));
      fork
         begin
            send_vec(xa, 1'b0);
            send_vec(xb, 1'b0);
         end
         collect(2 * NO, 1'b0);
      join
      check("back-to-back s_ready_x stalls", x_stalls, 0);
      compare_outputs("b2b");

      // Output back-pressure while both banks fill and a third vector waits.
      do_reset();
      load_filter(fv);
      y_ready = 1'b0;
      send_vec(xa, 1'b0);
      seen = 0;
      for (int t = 0; t < 50 && !seen; t++) begin
         @(negedge clk);
         if (y_valid) seen = 1;
      end
      if (!seen) fail_timeout("first m_valid_y");
      @(posedge clk); #1;
      hold_bad = 0;
      for (int i = 0; i < LX; i++) xc[i] = W'(3 * i);
      fork
         begin
            repeat (10) begin
               @(negedge clk);
               if (!y_valid || int'($signed(y_data)) != 30) hold_bad++;
            end
         end
         begin
            send_vec(xb, 1'b0);
            check("s_ready_x with both banks full", int'(x_ready), 0);
            x_data  = xc[0];
            x_valid = 1'b1;
            repeat (2) begin
               @(posedge clk); #1;
            end
            check("s_ready_x third vector blocked", int'(x_ready), 0);
            x_valid = 1'b0;
         end
      join
      check("held output unstable cycles", hold_bad, 0);
      check("held m_data_out_y", int'($signed(y_data)), 30);
      collect(2 * NO, 1'b0);
      exp_q.delete();
      for (int k = 0; k < NO; k++) exp_q.push_back(model_y(fv, xa, 1'b0, k));
      for (int k = 0; k < NO; k++) exp_q.push_back(model_y(fv, xb, 1'b0, k));
      compare_outputs("backpressure");

      // P=5: reset during MAC discards everything, including the filter.
      sel = 1'b1;
      do_reset();
      load_filter(fv);
      send_vec(xa, 1'b0);
      repeat (2) begin
         @(posedge clk); #1;
      end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("p5 mid-MAC reset s_ready_f", int'(f_ready), 1);
      check("p5 mid-MAC reset s_ready_x", int'(x_ready), 1);
      check("p5 mid-MAC reset m_valid_y", int'(y_valid), 0);
      check("p5 mid-MAC reset m_data_out_y", int'(y_data), 0);
      send_vec(xa, 1'b0);
      seen = 0;
      repeat (12) begin
         @(negedge clk);
         if (y_valid) seen++;
      end
      @(posedge clk); #1;
      check("p5 output without filter", seen, 0);
      load_filter(fv);
      collect(NO, 1'b0);
      exp_q.delete();
      for (int k = 0; k < NO; k++) exp_q.push_back(int'($signed(tv[0].y[k])));
      compare_outputs("p5 reload");

      // Randomized streams on both lane counts against the model.
      for (int run = 0; run < 4; run++) begin
         sel  = run[0];
         relu = 1'($urandom);
         do_reset();
         for (int j = 0; j < LF; j++)
            fv[j] = $urandom_range(0, 1) ? W'($urandom) : W'($urandom_range(0, 8) - 4);
         exp_q.delete();
         for (int v = 0; v < 4; v++) begin
            for (int i = 0; i < LX; i++)
               rv[v][i] = $urandom_range(0, 1) ? W'($urandom) : W'($urandom_range(0, 20) - 10);
            for (int k = 0; k < NO; k++) exp_q.push_back(model_y(fv, rv[v], relu, k));
         end
         load_filter(fv);
         fork
            for (int v = 0; v < 4; v++) send_vec(rv[v], 1'b1);
            collect(4 * NO, 1'b1);
         join
         compare_outputs($sformatf("rand%0d p%0d", run, sel ? 5 : 1));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
